mant_mul_pipe: RTL and testbench



---
 rtl/mant_mul_pipe.sv | 115 +++++++++++
 tb/tb_mant_mul_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mant_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mant_mul_pipe
//  Description : Pipelined unsigned mantissa multiplier with valid/ready
//                handshake, normalisation and truncate / round-to-nearest-even
//                rounding.
//                Stage 1 registers the operands. The multiply, normalise and
//                round step sits between stage 1 and stage 2. Stages 3..STAGES
//                only delay the finished result.
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                in_valid   operands present           in_ready  accept this cycle
//                a, b       W-bit unsigned mantissas
//                out_valid  result present             out_ready consumer takes it
//                prod       normalised, rounded W-bit product
//                norm       product bit 2W-1 was set (exponent +1)
//                rnd_carry  rounding overflowed, prod = 100..0 (exponent +1 more)
//                inexact    guard or sticky bit was set
//  Revision    : 1.0  initial release
// ============================================================================
module mant_mul_pipe #(
    parameter int W      = 24,
    parameter int STAGES = 3,
    parameter int ROUND  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] prod,
    output logic         norm,
    output logic         rnd_carry,
    output logic         inexact
);

    // Result record carried down the pipe: {prod, norm, rnd_carry, inexact}
    localparam int   c_RES_W    = W + 3;
    localparam logic c_ROUND_EN = (ROUND != 0);

    // Stage 1: captured operands; r_vld[k] is the valid bit of stage k
    logic [W-1:0]                   r_a;
    logic [W-1:0]                   r_b;
    logic [STAGES:1]                r_vld;
    // r_res[k] holds the result record of stage k+1
    logic [STAGES-1:1][c_RES_W-1:0] r_res;

    logic                           w_adv;
    logic [2*W-1:0]                 w_p;
    logic                           w_norm;
    logic [W-1:0]                   w_m;
    logic                           w_guard;
    logic                           w_sticky;
    logic                           w_inc;
    logic [W:0]                     w_sum;
    logic                           w_carry;
    logic [W-1:0]                   w_prod;
    logic [c_RES_W-1:0]             w_res;

    // Whole pipe moves together; it only stalls when a result is waiting
    // at the output and the consumer is not taking it.
    assign w_adv    = out_ready | ~r_vld[STAGES];
    assign in_ready = w_adv;

    // Multiply, normalise and round the stage-1 operands
    always_comb begin
        w_p    = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
        w_norm = w_p[2*W-1];
        if (w_norm) begin
            w_m      = w_p[2*W-1:W];
            w_guard  = w_p[W-1];
            w_sticky = |w_p[W-2:0];
        end else begin
            w_m      = w_p[2*W-2:W-1];
            w_guard  = w_p[W-2];
            w_sticky = |w_p[W-3:0];
        end
        // Round-to-nearest-even: round up above the halfway point, or on an
        // exact tie when the kept LSB is odd.
        w_inc   = c_ROUND_EN & w_guard & (w_sticky | w_m[0]);
        w_sum   = {1'b0, w_m} + {{W{1'b0}}, w_inc};
        // A carry out of the sum can only happen when m was all ones, so the
        // renormalised mantissa is exactly 1 followed by zeros.
        w_carry = w_sum[W];
        w_prod  = w_carry ? {1'b1, {(W-1){1'b0}}} : w_sum[W-1:0];
        w_res   = {w_prod, w_norm, w_carry, w_guard | w_sticky};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_vld <= '0;
            r_res <= '0;
        end else if (w_adv) begin
            // Operands shift in every advancing cycle; a bubble simply
            // carries a cleared valid bit alongside whatever data is there.
            r_a      <= a;
            r_b      <= b;
            r_vld    <= {r_vld[STAGES-1:1], in_valid};
            r_res[1] <= w_res;
            for (int k = 2; k < STAGES; k++) begin
                r_res[k] <= r_res[k-1];
            end
        end
    end

    assign out_valid                          = r_vld[STAGES];
    assign {prod, norm, rnd_carry, inexact}   = r_res[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_mant_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mant_mul_pipe
//  Description : Self-checking bench for mant_mul_pipe. Three instances:
//                d0 W=24 STAGES=3 round, d1 W=24 STAGES=5 truncate,
//                d2 W=4 STAGES=2 round. A per-instance scoreboard fed by an
//                arithmetic reference model checks every result taken.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mant_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [23:0] a;
    logic [23:0] b;

    logic        ir0, ov0, n0, c0, x0;
    logic [23:0] p0;
    logic        ir1, ov1, n1, c1, x1;
    logic [23:0] p1;
    logic        ir2, ov2, n2, c2, x2;
    logic [3:0]  p2;

    logic [26:0] o0, o1, o2;
    assign o0 = {p0, n0, c0, x0};
    assign o1 = {p1, n1, c1, x1};
    assign o2 = {20'b0, p2, n2, c2, x2};

    int n_cmp = 0;
    int n_err = 0;
    int pops0 = 0;
    int pops1 = 0;
    int pops2 = 0;

    logic [26:0] q0[$];
    logic [26:0] q1[$];
    logic [26:0] q2[$];
    logic        held0 = 1'b0;
    logic        held1 = 1'b0;
    logic [26:0] hold0;
    logic [26:0] hold1;

    always #5 clk = ~clk;

    mant_mul_pipe #(.W(24), .STAGES(3), .ROUND(1)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready),
        .prod(p0), .norm(n0), .rnd_carry(c0), .inexact(x0));

    mant_mul_pipe #(.W(24), .STAGES(5), .ROUND(0)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
        .prod(p1), .norm(n1), .rnd_carry(c1), .inexact(x1));

    mant_mul_pipe #(.W(4), .STAGES(2), .ROUND(1)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .a(a[3:0]), .b(b[3:0]), .out_valid(ov2), .out_ready(out_ready),
        .prod(p2), .norm(n2), .rnd_carry(c2), .inexact(x2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact product, then choose the kept window and round on the
    // numeric value of the discarded remainder compared with one half ulp.
    function automatic logic [26:0] model(input logic [23:0] x, input logic [23:0] y,
                                          input int w, input int rnd);
        longint unsigned p, m, rem, half, mx, my;
        int sh;
        bit nrm, cy, ix, up;
        mx   = longint'(x) & ((64'd1 << w) - 1);
        my   = longint'(y) & ((64'd1 << w) - 1);
        p    = mx * my;
        nrm  = ((p >> (2*w-1)) & 1) != 0;
        sh   = nrm ? w : w - 1;
        m    = p >> sh;
        rem  = p - (m << sh);
        half = 64'd1 << (sh - 1);
        ix   = (rem != 0);
        up   = (rnd != 0) && ((rem > half) || ((rem == half) && ((m & 1) != 0)));
        m    = m + (up ? 1 : 0);
        cy   = (m == (64'd1 << w));
        if (cy) m = 64'd1 << (w - 1);
        return {m[23:0], nrm, cy, ix};
    endfunction

    // Scoreboard: pops results as they are taken, pushes the model result
    // for every operand pair accepted in the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            q2.delete();
            held0 = 1'b0;
            held1 = 1'b0;
        end else begin
            if (held0 && ov0) check("hold_stable_d0", o0, hold0);
            if (held1 && ov1) check("hold_stable_d1", o1, hold1);
            if (ov0 && out_ready) begin
                pops0++;
                if (q0.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out_d0: got %0h, expected no result", o0);
                end else check("result_d0", o0, q0.pop_front());
            end
            if (ov1 && out_ready) begin
                pops1++;
                if (q1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out_d1: got %0h, expected no result", o1);
                end else check("result_d1", o1, q1.pop_front());
            end
            if (ov2 && out_ready) begin
                pops2++;
                if (q2.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out_d2: got %0h, expected no result", o2);
                end else check("result_d2", o2, q2.pop_front());
            end
            held0 = ov0 && !out_ready;
            hold0 = o0;
            held1 = ov1 && !out_ready;
            hold1 = o1;
            if (in_valid && ir0) q0.push_back(model(a, b, 24, 1));
            if (in_valid && ir1) q1.push_back(model(a, b, 24, 0));
            if (in_valid && ir2) q2.push_back(model(a, b, 4, 1));
        end
    end

    typedef struct {
        int          unit;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] prod;
        logic        nrm;
        logic        cy;
        logic        ix;
    } vec_t;

    vec_t vecs[11];

    task automatic get_out(input int u, output logic v, output logic [23:0] p,
                           output logic n, output logic c, output logic x);
        case (u)
            0:       begin v = ov0; p = p0;         n = n0; c = c0; x = x0; end
            1:       begin v = ov1; p = p1;         n = n1; c = c1; x = x1; end
            default: begin v = ov2; p = {20'b0, p2}; n = n2; c = c2; x = x2; end
        endcase
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic        vo, no, co, xo;
        logic [23:0] po;
        int          cyc;
        int          stg;
        stg = (v.unit == 0) ? 3 : (v.unit == 1) ? 5 : 2;
        a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        cyc = 1;
        get_out(v.unit, vo, po, no, co, xo);
        while (!vo && cyc < 20) begin
            @(posedge clk); #2;
            cyc++;
            get_out(v.unit, vo, po, no, co, xo);
        end
        $display("vector %0d unit %0d: a=%h b=%h prod=%h", idx, v.unit, v.a, v.b, po);
        check("vec_latency", cyc, stg);
        check("vec_prod", po, v.prod);
        check("vec_norm", no, v.nrm);
        check("vec_rnd_carry", co, v.cy);
        check("vec_inexact", xo, v.ix);
        repeat (6) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int cyc;
        int snap;
        logic acc;

        vecs[0]  = '{0, 24'hC00000, 24'hC00000, 24'h900000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0, 24'h800000, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{0, 24'hC00001, 24'hC00000, 24'h900001, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1, 24'hC00001, 24'hC00000, 24'h900000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{2, 24'h000009, 24'h00000E, 24'h000008, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{0, 24'h000000, 24'h123456, 24'h000000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2, 24'h00000F, 24'h00000F, 24'h00000E, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{2, 24'h00000C, 24'h000005, 24'h000008, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{2, 24'h00000D, 24'h000004, 24'h000006, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", {ov0, ov1, ov2}, 3'b000);
        check("rst_in_ready", {ir0, ir1, ir2}, 3'b111);
        check("rst_outputs_d0", o0, 27'h0);
        check("rst_outputs_d2", o2, 27'h0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Directed vectors
        for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

        // Back-pressure: five back-to-back pairs, consumer stalls from the
        // second cycle and resumes at the ninth.
        snap = pops0;
        i = 0; cyc = 0;
        out_ready = 1'b1;
        while (i < 5 && cyc < 50) begin
            a = 24'($urandom) | 24'h800000;
            b = 24'($urandom) | 24'h800000;
            in_valid = 1'b1;
            if (cyc == 1) out_ready = 1'b0;
            if (cyc == 8) out_ready = 1'b1;
            @(negedge clk);
            acc = ir0;
            if (cyc >= 3 && cyc <= 7) begin
                check("bp_in_ready_low", ir0, 1'b0);
                check("bp_out_valid_high", ov0, 1'b1);
            end
            @(posedge clk); #2;
            cyc++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", i, 5);
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("bp_result_count", pops0 - snap, 5);

        // Random traffic with random back-pressure
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            a = 24'($urandom);
            b = 24'($urandom);
            if ($urandom_range(0, 3) != 0) a[23] = 1'b1;
            if ($urandom_range(0, 3) != 0) b[23] = 1'b1;
            @(posedge clk); #2;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("drain_empty_d0", q0.size(), 0);
        check("drain_empty_d1", q1.size(), 0);
        check("drain_empty_d2", q2.size(), 0);

        // Reset with three results in flight
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 24'($urandom) | 24'h800000;
            b = 24'($urandom) | 24'h800000;
            in_valid = 1'b1;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {ov0, ov1, ov2}, 3'b000);
        check("midrst_outputs_d0", o0, 27'h0);
        check("midrst_outputs_d1", o1, 27'h0);
        check("midrst_outputs_d2", o2, 27'h0);
        check("midrst_in_ready", {ir0, ir1, ir2}, 3'b111);
        @(posedge clk); #2;
        rst_n = 1'b1;
        snap = pops0;
        a = 24'h800000; b = 24'h800000; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        cyc = 1;
        while (!ov0 && cyc < 20) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("postrst_latency", cyc, 3);
        check("postrst_prod", p0, 24'h800000);
        repeat (10) @(posedge clk);
        #2;
        check("postrst_result_count", pops0 - snap, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
